cond_jump_sequencer: RTL and testbench

- Sequences conditional jumps for the 8-bit CPU.
- Accepts instruction bytes from the decoder and detects conditional-jump instructions (mode 11, bits[5:3]=000, condition code in bits[2:0]).
- Latches the tested register value and the jump target, evaluates the condition, and drives the PC load.
- After a taken jump, holds the fetch pipeline in flush for a configurable number of cycles. Sits between the decoder, the register file read ports and the program counter.

---
 rtl/cond_jump_if.sv | 32 +++
 rtl/cond_jump_sequencer.sv | 138 +++++++++++++
 tb/tb_cond_jump_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cond_jump_if.sv
// cond_jump_if: decoder-to-sequencer instruction handshake.
//   instr_valid  decoder presents an instruction byte
//   instr        instruction byte
//   instr_ready  sequencer can accept an instruction
//   cond_value   tested register value, sampled with the instruction
//   target_addr  jump target, sampled with the instruction
// master = decoder side, slave = sequencer side.
interface cond_jump_if #(
  parameter int ADDR_W = 8
);
  logic              instr_valid;
  logic [7:0]        instr;
  logic              instr_ready;
  logic [7:0]        cond_value;
  logic [ADDR_W-1:0] target_addr;

  modport master (
    output instr_valid,
    output instr,
    output cond_value,
    output target_addr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  cond_value,
    input  target_addr,
    output instr_ready
  );
endinterface

// File: rtl/cond_jump_sequencer.sv
// cond_jump_sequencer: detects conditional-jump bytes (11_000_ccc), evaluates
// the condition on the sampled register value, pulses the PC load with the
// sampled target and holds the fetch pipeline in flush afterwards.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          decoder handshake (slave side): instr_valid/instr/instr_ready,
//                cond_value, target_addr
//   resolved     one-cycle pulse, condition evaluated
//   taken        condition result, valid while resolved
//   pc_load      one-cycle pulse, PC loads pc_next
//   pc_next      jump target, holds its last value outside pc_load
//   flush        fetch/decode flush, FLUSH_CYCLES cycles after a taken jump
//   busy         sequencer not idle
//   jump_count   saturating count of taken jumps
//
// state | meaning
// IDLE  | ready for an instruction byte
// EVAL  | condition result presented on resolved/taken
// LOAD  | pc_load pulse with the latched target
// FLUSH | flush asserted, down-counter running
module cond_jump_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  cond_jump_if.slave        bus,
  output logic              resolved,
  output logic              taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              flush,
  output logic              busy,
  output logic [7:0]        jump_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        code_q;
  logic [7:0]        value_q;
  logic [ADDR_W-1:0] target_q;
  logic [3:0]        flush_cnt;

  // Value is signed: bit 7 is the sign, zero detect from the full byte.
  function automatic logic cond_eval(input logic [2:0] code, input logic [7:0] v);
    logic neg;
    logic zero;
    logic hit;
    neg  = v[7];
    zero = (v == 8'h00);
    case (code[1:0])
      2'b00:   hit = 1'b0;
      2'b01:   hit = zero;
      2'b10:   hit = neg;
      default: hit = neg | zero;
    endcase
    // code[2] inverts the base test (never/always, ==0/!=0, <0/>=0, <=0/>0)
    return hit ^ code[2];
  endfunction

  logic is_jump;
  logic accept;

  assign is_jump         = (bus.instr[7:3] == 5'b11000);
  assign accept          = bus.instr_valid && (state == IDLE);
  assign bus.instr_ready = (state == IDLE);
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      code_q     <= '0;
      value_q    <= '0;
      target_q   <= '0;
      flush_cnt  <= '0;
      resolved   <= 1'b0;
      taken      <= 1'b0;
      pc_load    <= 1'b0;
      pc_next    <= '0;
      flush      <= 1'b0;
      jump_count <= '0;
    end else begin
      resolved <= 1'b0;
      taken    <= 1'b0;
      pc_load  <= 1'b0;
      case (state)
        IDLE: begin
          flush <= 1'b0;
          if (accept && is_jump) begin
            code_q   <= bus.instr[2:0];
            value_q  <= bus.cond_value;
            target_q <= bus.target_addr;
            // Outputs are registered, so the EVAL-cycle result is computed
            // from the same bytes being latched here.
            resolved <= 1'b1;
            taken    <= cond_eval(bus.instr[2:0], bus.cond_value);
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (cond_eval(code_q, value_q)) begin
            pc_load <= 1'b1;
            pc_next <= target_q;
            if (jump_count != 8'hFF) jump_count <= jump_count + 8'd1;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (FLUSH_CYCLES > 0) begin
            flush     <= 1'b1;
            flush_cnt <= 4'(FLUSH_CYCLES - 1);
            state     <= FLUSH;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_jump_sequencer.sv
// Bench for cond_jump_sequencer: two instances (FLUSH_CYCLES=2 and 0) share
// one stimulus stream; a timeline model predicts every output each cycle.
module tb_cond_jump_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_jump_if #(.ADDR_W(8)) bus0 ();
  cond_jump_if #(.ADDR_W(8)) bus1 ();

  logic [1:0] resolved, taken, pc_load, flush, busy;
  logic [7:0] pc_next [2];
  logic [7:0] jump_count [2];

  cond_jump_sequencer #(.ADDR_W(8), .FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .resolved(resolved[0]), .taken(taken[0]), .pc_load(pc_load[0]),
    .pc_next(pc_next[0]), .flush(flush[0]), .busy(busy[0]),
    .jump_count(jump_count[0])
  );

  cond_jump_sequencer #(.ADDR_W(8), .FLUSH_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .resolved(resolved[1]), .taken(taken[1]), .pc_load(pc_load[1]),
    .pc_next(pc_next[1]), .flush(flush[1]), .busy(busy[1]),
    .jump_count(jump_count[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: cycles elapsed since the accepting edge (0 = idle).
  // Phase 1 = result shown, 2 = PC load, 3..2+F = flush.
  int         phase [2];
  bit         m_taken [2];
  logic [7:0] m_tgt [2];
  logic [7:0] m_pc [2];
  int         m_cnt [2];

  function automatic int flen(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit cond_ref(input logic [2:0] code, input logic [7:0] raw);
    int v;
    v = $signed(raw);
    case (code)
      3'd0: return 1'b0;
      3'd1: return v == 0;
      3'd2: return v < 0;
      3'd3: return v <= 0;
      3'd4: return 1'b1;
      3'd5: return v != 0;
      3'd6: return v > 0;
      default: return v >= 0;
    endcase
  endfunction

  logic       in_valid;
  logic [7:0] in_instr, in_val, in_tgt;

  task automatic model_step();
    int last;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        phase[d] = 0; m_pc[d] = 8'h00; m_cnt[d] = 0; m_taken[d] = 1'b0;
      end else if (phase[d] == 0) begin
        if (in_valid && in_instr[7:3] == 5'b11000) begin
          phase[d]   = 1;
          m_taken[d] = cond_ref(in_instr[2:0], in_val);
          m_tgt[d]   = in_tgt;
        end
      end else begin
        last = m_taken[d] ? 2 + flen(d) : 1;
        phase[d] = phase[d] + 1;
        if (phase[d] > last) phase[d] = 0;
        if (phase[d] == 2) begin
          m_pc[d] = m_tgt[d];
          if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic rdy;
    for (int d = 0; d < 2; d++) begin
      rdy = (d == 0) ? bus0.instr_ready : bus1.instr_ready;
      check($sformatf("d%0d instr_ready", d), 32'(rdy),           32'(phase[d] == 0));
      check($sformatf("d%0d busy", d),        32'(busy[d]),       32'(phase[d] != 0));
      check($sformatf("d%0d resolved", d),    32'(resolved[d]),   32'(phase[d] == 1));
      check($sformatf("d%0d taken", d),       32'(taken[d]),      32'(phase[d] == 1 && m_taken[d]));
      check($sformatf("d%0d pc_load", d),     32'(pc_load[d]),    32'(phase[d] == 2));
      check($sformatf("d%0d flush", d),       32'(flush[d]),      32'(phase[d] >= 3));
      check($sformatf("d%0d pc_next", d),     32'(pc_next[d]),    32'(m_pc[d]));
      check($sformatf("d%0d jump_count", d),  32'(jump_count[d]), 32'(m_cnt[d]));
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] i, input logic [7:0] val, input logic [7:0] t);
    in_valid = v; in_instr = i; in_val = val; in_tgt = t;
    bus0.instr_valid = v; bus0.instr = i; bus0.cond_value = val; bus0.target_addr = t;
    bus1.instr_valid = v; bus1.instr = i; bus1.cond_value = val; bus1.target_addr = t;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Present one byte for one cycle, then let it run out with noise on the
  // value/target inputs, which must be ignored.
  task automatic single(input logic [7:0] i, input logic [7:0] val, input logic [7:0] t);
    drive(1'b1, i, val, t);
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'h00, 8'($urandom), 8'($urandom));
      cycle();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; m_taken[d] = 1'b0; m_tgt[d] = 8'h00; m_pc[d] = 8'h00; m_cnt[d] = 0;
    end
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    single(8'hC4, 8'h55, 8'h3A);
    check("first jump pc_next", 32'(pc_next[0]), 32'h3A);
    check("first jump count", 32'(jump_count[0]), 32'd1);

    single(8'hC2, 8'h80, 8'h11);
    single(8'hC2, 8'h7F, 8'h22);
    single(8'hC6, 8'h01, 8'h33);
    single(8'hC7, 8'hFF, 8'h44);

    drive(1'b1, 8'h45, 8'h00, 8'h66); cycle();
    drive(1'b1, 8'hC8, 8'h00, 8'h77); cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00); cycle();
    single(8'hC0, 8'h00, 8'h88);

    // Held request: target changes after the accepting edge.
    drive(1'b1, 8'hC1, 8'h00, 8'h10); cycle();
    drive(1'b1, 8'hC1, 8'h00, 8'h99); cycle();
    cycle();
    check("held pc_next keeps sample", 32'(pc_next[0]), 32'h10);
    repeat (6) cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (6) cycle();

    // Reset in FLUSH (dut0), then reset in EVAL.
    drive(1'b1, 8'hC4, 8'h00, 8'h5A); cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (3) cycle();
    check("dut0 in flush before reset", 32'(flush[0]), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("reset in flush count", 32'(jump_count[0]), 32'd0);
    cycle();
    drive(1'b1, 8'hC4, 8'h00, 8'h5B); cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("reset in eval busy", 32'(busy[0]), 32'd0);
    repeat (3) cycle();

    // Saturation: keep a taken jump pending for more than 256 jumps.
    for (int k = 0; k < 1350; k++) begin
      drive(1'b1, 8'hC4, 8'($urandom), 8'($urandom));
      cycle();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (6) cycle();
    check("dut0 saturated", 32'(jump_count[0]), 32'd255);
    check("dut1 saturated", 32'(jump_count[1]), 32'd255);

    reset = 1'b1; cycle(); reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] ins;
      ins = ($urandom_range(0, 3) != 0) ? (8'hC0 | 8'($urandom_range(0, 7))) : 8'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), ins, 8'($urandom), 8'($urandom));
      cycle();
    end
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
